mem_stream_fifo: RTL and testbench
==================================

// Module: mem_stream_fifo
// PURPOSE
//   Valid/ready stream FIFO controller built around the dual-port `mem` block (1-cycle synchronous read).
//   Accepts an upstream word stream and writes it into `mem` through the write port.
//   Fetches words back through the read port and presents them to a downstream consumer with full-throughput handshaking.
//   Hides the read latency behind a 2-entry output skid buffer.
// PARAMETERS
//   DATA_W    16    word width; must match the attached mem
//   MEM_SIZE  1000  mem depth in words; any value >= 2, not required to be a power of two
//   ADDR_W    $clog2(MEM_SIZE)  derived; do not override
//   CNT_W     $clog2(MEM_SIZE+3)  derived; width of count
// PORTS
//   clk           in   1       clock; all logic on posedge
//   rst           in   1       synchronous, active-high reset
//   in_valid      in   1       upstream word valid
//   in_ready      out  1       controller can accept; transfer = in_valid & in_ready
//   in_data       in   DATA_W  upstream word
//   out_valid     out  1       head word valid
//   out_ready     in   1       downstream accepts; transfer = out_valid & out_ready
//   out_data      out  DATA_W  head word (skid entry 0)
//   mem_write     out  1       to mem.write
//   mem_addr_w    out  ADDR_W  to mem.addr_w
//   mem_data_in   out  DATA_W  to mem.data_in
//   mem_read      out  1       to mem.read
//   mem_addr_r    out  ADDR_W  to mem.addr_r
//   mem_data_out  in   DATA_W  from mem.data_out; valid the cycle after mem_read
//   count         out  CNT_W   total words held (mem + in-flight + skid)
// BEHAVIOUR
//   State registers:
//     wr_ptr, rd_ptr: ADDR_W
//     mem_cnt: 0..MEM_SIZE, words written but not yet read-issued
//     rd_pend: read issued last cycle
//     occ: 0..2 skid entries
//   Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, mem_cnt=0, rd_pend=0, occ=0.
//     While rst is high: in_ready=0, out_valid=0, mem_write=0, mem_read=0, count=0.
//     mem contents are not cleared. Data of a read in flight at reset is discarded.
//   Write path:
//     in_ready = !rst & (mem_cnt < MEM_SIZE).
//     mem_write = in_valid & in_ready; mem_addr_w = wr_ptr; mem_data_in = in_data (combinational, same cycle).
//   Read issue (combinational from registered state):
//     mem_read = !rst & (mem_cnt > 0) & (occ + rd_pend - pop < 2), where pop = out_valid & out_ready.
//     mem_addr_r = rd_ptr.
//   Pointer wrap: wr_ptr/rd_ptr increment on their port's transfer; MEM_SIZE-1 -> 0 explicitly (no power-of-two rollover).
//   mem_cnt next = mem_cnt + mem_write - mem_read. Push and issue in the same cycle leave it unchanged.
//   Hazard avoidance: a read is issued only for entries counted in registered mem_cnt.
//     Every read therefore targets an address written at an earlier edge; same-cycle read/write of one address never occurs.
//   Return path: rd_pend <= mem_read. When rd_pend=1, mem_data_out is captured into the skid:
//     into entry occ-pop, so entry 0 is refilled in the same cycle it is popped.
//   Skid: out_valid = (occ > 0); out_data = entry 0.
//     On pop, entry 1 shifts to entry 0. occ next = occ + rd_pend - pop; never exceeds 2.
//   count = mem_cnt + rd_pend + occ. Maximum is MEM_SIZE+2; in_ready stays low while mem_cnt == MEM_SIZE.
//   Latency: a word pushed into an empty FIFO at edge N is issued at N+1, returns at N+2, and has out_valid=1 after edge N+2.
//   Throughput: 1 word/cycle sustained push and pop when out_ready=1.
//   Ordering: strict FIFO. No drops, no duplicates under any out_ready pattern.
// STRUCTURE
//   Package mem_stream_pkg:
//     - localparams DEFAULT_DATA_W=16, DEFAULT_MEM_SIZE=1000
//     - function ptr_inc(ptr, size) for the explicit wrap
//   Sub-module mem_stream_skid: 2-entry output buffer with capture/pop/shift logic and occ.
//   `mem` is instantiated by the parent and connected through the mem_* ports; it is not instantiated inside this block.
// TESTING
//   Bench connects this block to `mem` with MEM_SIZE=1000, DATA_W=16; scoreboard is a SV queue.
//   1. Fill: out_ready=0; push $urandom(seed=24) & 16'hFFFF words until in_ready=0.
//      -> Exactly 1002 accepted, count=1002. Then out_ready=1 -> 1002 words out in order, count=0, out_valid=0.
//   2. Latency: empty FIFO, push 16'hA5A5 at edge N.
//      -> mem_read=1 in cycle N+1 with mem_addr_r=0; out_valid=1, out_data=16'hA5A5 after edge N+2.
//   3. Streaming wrap: in_valid=1, out_ready=1 for 3000 cycles.
//      -> 1 word/cycle after 2-cycle fill; pointers wrap 999->0 three times; zero mismatches.
//   4. Backpressure: out_ready random 50%, in_valid random 70%, 5000 words.
//      -> Order preserved; occ never > 2; no mem_read while mem_cnt=0.
//   5. Full boundary: at count=1002, pop one with push held.
//      -> in_ready rises the following cycle; no word lost or overwritten.
//   6. Reset mid-stream: assert rst for 1 cycle with 37 words held and a read in flight.
//      -> Next cycle count=0, out_valid=0. Post-reset traffic passes from address 0 with no stale words.

Source files
------------

// File: rtl/mem_stream_pkg.sv
// Shared defaults and pointer helper for the mem-backed stream FIFO.
package mem_stream_pkg;

  localparam int unsigned DEFAULT_DATA_W   = 16;
  localparam int unsigned DEFAULT_MEM_SIZE = 1000;

  // Wraps at size-1 explicitly so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned size);
    return (ptr >= size - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_stream_skid.sv
// Two-entry output buffer absorbing the one-cycle synchronous read latency of mem.
module mem_stream_skid
  import mem_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              pop,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] ent0_q, ent1_q, ent0_d, ent1_d;
  logic [1:0]        occ_q, occ_d;

  assign out_valid = !rst && (occ_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = ent0_q;
  assign occ       = occ_q;

  // Capture slot is occ-pop, so entry 0 can be refilled in the cycle it is popped.
  always_comb begin
    ent0_d = pop ? ent1_q : ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q + {1'b0, cap_valid} - {1'b0, pop};
    if (cap_valid) begin
      if ((occ_q - {1'b0, pop}) == 2'd0)
        ent0_d = cap_data;
      else
        ent1_d = cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      occ_q <= '0;
    else
      occ_q <= occ_d;
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

endmodule

// File: rtl/mem_stream_fifo.sv
// Valid/ready stream FIFO controller driving an external dual-port mem with 1-cycle reads.
module mem_stream_fifo
  import mem_stream_pkg::*;
#(
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int unsigned ADDR_W   = $clog2(MEM_SIZE),
  parameter int unsigned CNT_W    = $clog2(MEM_SIZE + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] MEM_FULL = CNT_W'(MEM_SIZE);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  mem_cnt;
  logic              rd_pend;
  logic [1:0]        occ;
  logic              pop;
  logic [2:0]        skid_lvl;

  assign in_ready    = !rst && (mem_cnt < MEM_FULL);
  assign mem_write   = in_valid & in_ready;
  assign mem_addr_w  = wr_ptr;
  assign mem_data_in = in_data;

  // Reads come only from registered mem_cnt, so a read never hits the address written this cycle.
  assign skid_lvl   = {1'b0, occ} + {2'b00, rd_pend};
  assign mem_read   = !rst && (mem_cnt != '0) && (skid_lvl < (3'd2 + {2'b00, pop}));
  assign mem_addr_r = rd_ptr;

  assign count = rst ? '0 : (mem_cnt + CNT_W'(rd_pend) + CNT_W'(occ));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (mem_write)
        wr_ptr <= ADDR_W'(ptr_inc(32'(wr_ptr), MEM_SIZE));
      if (mem_read)
        rd_ptr <= ADDR_W'(ptr_inc(32'(rd_ptr), MEM_SIZE));
      mem_cnt <= mem_cnt + CNT_W'(mem_write) - CNT_W'(mem_read);
      rd_pend <= mem_read;
    end
  end

  mem_stream_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .cap_valid(rd_pend),
    .cap_data (mem_data_out),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .pop      (pop),
    .occ      (occ)
  );

endmodule

// File: tb/tb_mem_stream_fifo.sv
// Bench for mem_stream_fifo: directed vector table plus queue-scoreboarded random traffic.
module tb_mem_stream_fifo;

  localparam int DW = 16;
  localparam int MS = 1000;
  localparam int AW = 10;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          mem_write;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_data_in;
  logic          mem_read;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_data_out;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  mem_stream_fifo #(
    .DATA_W  (DW),
    .MEM_SIZE(MS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .mem_write   (mem_write),
    .mem_addr_w  (mem_addr_w),
    .mem_data_in (mem_data_in),
    .mem_read    (mem_read),
    .mem_addr_r  (mem_addr_r),
    .mem_data_out(mem_data_out),
    .count       (count)
  );

  // Behavioural dual-port mem with 1-cycle synchronous read.
  logic [DW-1:0] mem_arr [MS];
  always @(posedge clk) begin
    if (mem_write) mem_arr[mem_addr_w] <= mem_data_in;
    if (mem_read)  mem_data_out <= mem_arr[mem_addr_r];
  end

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  // Reference model state
  logic [DW-1:0] q[$];
  int backlog = 0;   // words written to mem, not yet read-issued
  int held = 0;      // words returned from mem, not yet popped
  int ret = 0;       // read issued in the previous cycle
  int wa = 0, ra = 0;
  int wr_wraps = 0;
  int n_push = 0, n_pop = 0;
  logic s_in_ready;

  task automatic step();
    logic push, pop;
    #1;
    push = in_valid & in_ready;
    pop  = out_valid & out_ready;
    s_in_ready = in_ready;
    if (rst) begin
      chk("rst_count", 32'(count), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_mem_read", 32'(mem_read), 0);
      chk("rst_mem_write", 32'(mem_write), 0);
    end else begin
      chk("count", 32'(count), q.size());
      chk("in_ready", 32'(in_ready), 32'(backlog < MS));
      chk("out_valid", 32'(out_valid), 32'(held > 0));
      chk("mem_write", 32'(mem_write), 32'(push));
      if (pop) begin
        chk("pop_nonempty", 32'(q.size() > 0), 1);
        if (q.size() > 0) chk("out_data", 32'(out_data), 32'(q.pop_front()));
        n_pop++;
      end
      if (push) begin
        chk("addr_w", 32'(mem_addr_w), wa);
        q.push_back(in_data);
        if (wa == MS - 1) begin wa = 0; wr_wraps++; end else wa++;
        n_push++;
      end
      if (mem_read) begin
        chk("rd_nonempty", 32'(backlog > 0), 1);
        chk("addr_r", 32'(mem_addr_r), ra);
        ra = (ra == MS - 1) ? 0 : ra + 1;
      end
      backlog = backlog + int'(push) - int'(mem_read);
      held    = held + ret - int'(pop);
      chk("occ_le2", 32'(held <= 2 && held >= 0), 1);
      ret = int'(mem_read);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      backlog = 0; held = 0; ret = 0; wa = 0; ra = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while ((q.size() != 0 || held != 0) && cyc < 3000) begin
      step();
      cyc++;
    end
    chk("drain_done", q.size(), 0);
    #1;
    chk("drain_count", 32'(count), 0);
    chk("drain_out_valid", 32'(out_valid), 0);
    step();
  endtask

  task automatic run_random(input int n_words, input int pv, input int pr, input int maxcyc);
    int start, cyc;
    start = n_push; cyc = 0;
    while (n_push - start < n_words && cyc < maxcyc) begin
      in_valid  = ($urandom_range(0, 99) < pv);
      in_data   = DW'($urandom & 32'hFFFF);
      out_ready = ($urandom_range(0, 99) < pr);
      step();
      cyc++;
    end
    chk("rand_words", n_push - start, n_words);
  endtask

  typedef struct {
    logic          rst, iv;
    logic [DW-1:0] din;
    logic          ordy;
    logic          e_ir, e_mw, e_mr;
    logic [AW-1:0] e_ar;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, p0, w0;
    tbl[0]  = '{1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b0,10'd0,1'b0,16'h0000,10'd0};
    tbl[1]  = '{1'b0,1'b1,16'hA5A5,1'b0, 1'b1,1'b1,1'b0,10'd0,1'b0,16'h0000,10'd0};
    tbl[2]  = '{1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b1,10'd0,1'b0,16'h0000,10'd1};
    tbl[3]  = '{1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,10'd0,1'b0,16'h0000,10'd1};
    tbl[4]  = '{1'b0,1'b1,16'h1234,1'b0, 1'b1,1'b1,1'b0,10'd0,1'b1,16'hA5A5,10'd1};
    tbl[5]  = '{1'b0,1'b1,16'h5678,1'b0, 1'b1,1'b1,1'b1,10'd1,1'b1,16'hA5A5,10'd2};
    tbl[6]  = '{1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,10'd0,1'b1,16'hA5A5,10'd3};
    tbl[7]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b1,10'd2,1'b1,16'hA5A5,10'd3};
    tbl[8]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b0,10'd0,1'b1,16'h1234,10'd2};
    tbl[9]  = '{1'b0,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b0,10'd0,1'b1,16'h5678,10'd1};
    tbl[10] = '{1'b0,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,10'd0,1'b0,16'h0000,10'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Directed vectors: reset, single-word latency, skid fill/refill-on-pop.
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].din; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
      chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(tbl[i].e_mw));
      chk($sformatf("v%0d_mem_read", i), 32'(mem_read), 32'(tbl[i].e_mr));
      if (tbl[i].e_mr) chk($sformatf("v%0d_addr_r", i), 32'(mem_addr_r), 32'(tbl[i].e_ar));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov) chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      @(posedge clk);
      @(negedge clk);
    end

    // Fill until in_ready drops with the consumer stalled.
    void'($urandom(24));
    do_reset();
    n0 = n_push;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      in_data = DW'($urandom & 32'hFFFF);
      step();
      if (!s_in_ready) break;
    end
    chk("fill_accepted", n_push - n0, 1002);
    #1;
    chk("fill_count", 32'(count), 1002);

    // Full boundary: pop one with push held; in_ready returns next cycle.
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    chk("full_reaccept_ready", 32'(s_in_ready), 1);
    chk("full_reaccept_push", n_push - n0, 1003);
    drain();

    // Streaming with pointer wrap from a fresh reset.
    do_reset();
    n0 = n_push; p0 = n_pop; w0 = wr_wraps;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      in_data = DW'($urandom & 32'hFFFF);
      step();
    end
    chk("stream_push", n_push - n0, 3000);
    chk("stream_pop", n_pop - p0, 2997);
    chk("stream_wraps", wr_wraps - w0, 3);
    drain();

    // Random backpressure.
    run_random(5000, 70, 50, 40000);
    drain();

    // Reset with 37 words held and a read in flight.
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 38; c++) begin
      in_data = DW'($urandom & 32'hFFFF);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    #1;
    chk("prerst_count", 32'(count), 37);
    chk("prerst_rd_inflight", ret, 1);
    rst = 1'b1; out_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("postrst_count", 32'(count), 0);
    chk("postrst_out_valid", 32'(out_valid), 0);
    run_random(200, 70, 60, 4000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
